div_sign_ctrl: RTL

Sequential front/back stage wrapped around the combinational 32-bit unsigned divider, implementing RISC-V M-extension DIV/DIVU/REM/REMU.
- Accepts operands over a valid/ready handshake and converts signed operands to magnitudes.
- Drives the divider and holds its inputs stable for a programmable multicycle window.
- Samples quotient/remainder, applies sign correction and architectural special cases, and presents one registered result to writeback.

---
 rtl/div_sign_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div_sign_ctrl.sv
// rtl/div_sign_ctrl.sv - sign/special-case wrapper around a combinational unsigned divider
// Optional DIV_RESULT_CACHE_EN keeps the last completed result pair for a 1-cycle replay.
module div_sign_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int TAG_W       = 5
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_rem, r_sign_a, r_sign_b;
  logic        w_sign_a, w_sign_b, w_div_zero, w_ovf, w_fast;
  logic [31:0] w_mag_a, w_mag_b, w_special_res, w_fast_res, w_q, w_r;

  assign w_sign_a   = in_a[31] & ~in_op[0];
  assign w_sign_b   = in_b[31] & ~in_op[0];
  assign w_mag_a    = w_sign_a ? (32'd0 - in_a) : in_a;
  assign w_mag_b    = w_sign_b ? (32'd0 - in_b) : in_b;
  assign w_div_zero = (in_b == 32'd0);
  assign w_ovf      = ~in_op[0] && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero)
      w_special_res = in_op[1] ? in_a : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_special_res = in_op[1] ? 32'd0 : 32'h8000_0000;
  end

  assign w_q = (r_sign_a ^ r_sign_b) ? (32'd0 - div_quotient) : div_quotient;
  assign w_r = r_sign_a ? (32'd0 - div_remainder) : div_remainder;

`ifdef DIV_RESULT_CACHE_EN
  logic        r_c_valid, r_c_uns, r_req_uns, r_cacheable;
  logic [31:0] r_c_a, r_c_b, r_c_q, r_c_r, r_req_a, r_req_b, r_res_q, r_res_r;
  logic        w_hit;

  assign w_hit = r_c_valid && (in_a == r_c_a) && (in_b == r_c_b) && (in_op[0] == r_c_uns);

  // Only divider-sampled results are cached; special cases are already single-cycle.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_c_valid   <= 1'b0;
      r_c_uns     <= 1'b0;
      r_c_a       <= 32'd0;
      r_c_b       <= 32'd0;
      r_c_q       <= 32'd0;
      r_c_r       <= 32'd0;
      r_req_uns   <= 1'b0;
      r_req_a     <= 32'd0;
      r_req_b     <= 32'd0;
      r_res_q     <= 32'd0;
      r_res_r     <= 32'd0;
      r_cacheable <= 1'b0;
    end else if (flush) begin
      r_c_valid   <= 1'b0;
      r_cacheable <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_req_a     <= in_a;
        r_req_b     <= in_b;
        r_req_uns   <= in_op[0];
        r_cacheable <= 1'b0;
      end
      if (r_state == S_WAIT && r_cnt == 4'd0) begin
        r_res_q     <= w_q;
        r_res_r     <= w_r;
        r_cacheable <= 1'b1;
      end
      if (r_state == S_DONE && out_ready && r_cacheable) begin
        r_c_valid <= 1'b1;
        r_c_a     <= r_req_a;
        r_c_b     <= r_req_b;
        r_c_uns   <= r_req_uns;
        r_c_q     <= r_res_q;
        r_c_r     <= r_res_r;
      end
    end
  end
`endif

  always_comb begin
    w_fast     = w_div_zero || w_ovf;
    w_fast_res = w_special_res;
`ifdef DIV_RESULT_CACHE_EN
    if (!w_fast && w_hit) begin
      w_fast     = 1'b1;
      w_fast_res = in_op[1] ? r_c_r : r_c_q;
    end
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_fast ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_rem        <= 1'b0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      out_result   <= 32'd0;
      out_tag      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid && !flush) begin
        r_rem        <= in_op[1];
        r_sign_a     <= w_sign_a;
        r_sign_b     <= w_sign_b;
        div_dividend <= w_mag_a;
        div_divisor  <= w_mag_b;
        out_tag      <= in_tag;
        r_cnt        <= LP_CNT_INIT;
        if (w_fast) out_result <= w_fast_res;
      end else if (r_state == S_WAIT) begin
        if (r_cnt == 4'd0)
          out_result <= r_rem ? w_r : w_q;
        else
          r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule
